fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the pipelined RV32I core, directly upstream of the IF/ID decode register. Owns the PC register, issues one instruction-memory request at a time over a request/response interface, and applies branch/jump redirects from Execute. Presents `RD`/`PC`/`PCPlus4` plus a valid flag to the decode register, and honours stalls from the hazard unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `StallF`  in  1: hazard-unit stall; hold the current instruction.
- `PCSrcE`  in  1: redirect request from Execute.
- `PCTargetE`  in  32: redirect target.
- `imem_req`  out  1: one-cycle request strobe.
- `imem_addr`  out  32: request address, valid while `imem_req`=1.
- `imem_rvalid`  in  1: response strobe, exactly one per request, at least 1 cycle after it.
- `imem_rdata`  in  32: instruction word, valid with `imem_rvalid`.
- `RD`  out  32: instruction to decode register.
- `PC`  out  32: address of `RD`.
- `PCPlus4`  out  32: `PC`+4.
- `InstrValidF`  out  1: `RD`/`PC` are a valid, right-path instruction this cycle.

## Operation
- State: `PCF` (32), instruction buffer `buf` (32), FSM `IDLE`, `WAIT`, `READY`, `DROP`. At most one request outstanding.
- `PC`=`PCF`; `PCPlus4`=`PCF`+4, modulo 2^32 (0xFFFF_FFFC+4 = 0).
- `RD`=`imem_rdata` in `WAIT`, `buf` otherwise.
- `InstrValidF`=((`WAIT` & `imem_rvalid`) | `READY`) & ~`PCSrcE`.
- consume = `InstrValidF` & ~`StallF`.
- `IDLE`:
  - Assert `imem_req`. `imem_addr`=`PCF`, or `PCTargetE` if `PCSrcE`; in that case load it into `PCF`.
  - Go to `WAIT`.
- `WAIT`:
  - No `imem_rvalid`, no `PCSrcE`: stay.
  - No `imem_rvalid`, `PCSrcE`: `PCF`<=`PCTargetE`, go to `DROP`.
  - `imem_rvalid` & `PCSrcE`: discard data. Request `PCTargetE` this cycle. `PCF`<=`PCTargetE`. Stay in `WAIT`.
  - `imem_rvalid` & consume: `PCF`<=`PCF`+4. Request `PCF`+4 this cycle. Stay in `WAIT`.
  - `imem_rvalid` & `StallF`: `buf`<=`imem_rdata`, go to `READY`.
- `READY`:
  - `PCSrcE`: discard `buf`. Request `PCTargetE`. `PCF`<=`PCTargetE`. Go to `WAIT`.
  - consume: `PCF`<=`PCF`+4. Request `PCF`+4. Go to `WAIT`.
  - `StallF`: hold everything.
- `DROP` (wrong-path response pending):
  - Further `PCSrcE`: `PCF`<=`PCTargetE`; takes priority over stale target.
  - On `imem_rvalid`: discard data. Request `PCF` (or `PCTargetE` if `PCSrcE` same cycle). Go to `WAIT`.
- `PCSrcE` has priority over `StallF` in every state.
- `imem_rvalid` in `IDLE`/`READY` is a protocol violation: ignored, no state change.
- Integration: decode register `CLR` = `FlushD` | ~`InstrValidF`, so bubbles enter Decode when no instruction is valid.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - Internal state: `PCF`=`RESET_PC`, `buf`=0, state `IDLE`.
  - Outputs: `imem_req`=0 (gated by `rst_n`), `InstrValidF`=0, `RD`=0, `PC`=`RESET_PC`, `PCPlus4`=`RESET_PC`+4.
- First request is issued in the first cycle with `rst_n`=1.
- `imem_req` and `imem_addr` are combinational from state and inputs. Requests go out in the same cycle as consume/redirect.
- With 1-cycle memory latency and no stalls, throughput is one instruction per cycle.
- Redirect penalty: the target instruction is valid no earlier than `PCTargetE` cycle + memory latency (+1 if a stale response is still outstanding).
- Reset mid-transaction: the FSM returns to `IDLE`. An in-flight response after reset release is ignored only if it arrives in `IDLE`. The memory model must be reset together with this block.

## Structure
- Shared package `fetch_pkg`: `fetch_state_t` enum (`IDLE`, `WAIT`, `READY`, `DROP`) and `NOP_INSTR` = 32'h0000_0013 for bench and hazard use.
- Single module, no sub-modules. The PC adder and the address mux are inline.

## Test plan
- Reset release with `RESET_PC`=0, 1-cycle memory -> `imem_addr` sequence 0,4,8,C. `InstrValidF` first high 1 cycle after the first request, then high every cycle.
- `StallF` held 3 cycles while the instruction at 0x8 is valid -> `RD`/`PC`=0x8 stable, no new `imem_req`. Request for 0xC on the cycle `StallF` drops.
- `PCSrcE`=1, `PCTargetE`=0x100 while a request for 0x10 is outstanding (3-cycle memory) -> state `DROP`, the 0x10 data never shows `InstrValidF`, next request is 0x100.
- `PCSrcE` in the same cycle as `imem_rvalid` -> `InstrValidF`=0, `imem_req` with `imem_addr`=`PCTargetE` that cycle.
- Two redirects (0x200 then 0x300) during `DROP` -> only 0x300 is requested after the stale response.
- `PCF`=0xFFFF_FFFC, consumed -> `PCPlus4`=0, next `imem_addr`=0. Asynchronous reset asserted mid-`WAIT` -> outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, used by the fetch unit, hazard logic and benches.
// No logic, no latency.
// No flow control.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0: the bubble the decode register holds when cleared
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response link: single-cycle request strobe, one response strobe per request.
// Response latency is set by the memory (at least one cycle).
// No backpressure; the fetch side never has more than one request outstanding.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns PCF, issues one imem request at a time, applies Execute redirects.
// Latency: instruction valid in the cycle its response arrives; request issued combinationally on consume/redirect.
// Backpressure: StallF parks a returned instruction in a buffer; PCSrcE overrides StallF.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                StallF,
    input  logic                PCSrcE,
    input  logic [31:0]         PCTargetE,
    fetch_unit_if.master        imem,
    output logic [31:0]         RD,
    output logic [31:0]         PC,
    output logic [31:0]         PCPlus4,
    output logic                InstrValidF
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  instr_buf_q, instr_buf_d;

    logic [31:0]  pc_plus4;
    logic         instr_vld;
    logic         consume;
    logic         req;
    logic [31:0]  req_addr;

    always_comb begin
        pc_plus4    = pc_next(pcf_q);
        instr_vld   = ((state_q == WAIT && imem.imem_rvalid) || state_q == READY) && !PCSrcE;
        consume     = instr_vld && !StallF;

        state_d     = state_q;
        pcf_d       = pcf_q;
        instr_buf_d = instr_buf_q;
        req         = 1'b0;
        req_addr    = pcf_q;

        case (state_q)
            IDLE: begin
                req     = 1'b1;
                state_d = WAIT;
                if (PCSrcE) begin
                    req_addr = PCTargetE;
                    pcf_d    = PCTargetE;
                end
            end

            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (PCSrcE) begin
                        req      = 1'b1;
                        req_addr = PCTargetE;
                        pcf_d    = PCTargetE;
                    end else if (consume) begin
                        req      = 1'b1;
                        req_addr = pc_plus4;
                        pcf_d    = pc_plus4;
                    end else begin
                        instr_buf_d = imem.imem_rdata;
                        state_d     = READY;
                    end
                end else if (PCSrcE) begin
                    // the outstanding response is now wrong-path; wait it out in DROP
                    pcf_d   = PCTargetE;
                    state_d = DROP;
                end
            end

            READY: begin
                if (PCSrcE) begin
                    req      = 1'b1;
                    req_addr = PCTargetE;
                    pcf_d    = PCTargetE;
                    state_d  = WAIT;
                end else if (consume) begin
                    req      = 1'b1;
                    req_addr = pc_plus4;
                    pcf_d    = pc_plus4;
                    state_d  = WAIT;
                end
            end

            DROP: begin
                // a newer redirect always replaces the remembered target
                if (PCSrcE) begin
                    pcf_d = PCTargetE;
                end
                if (imem.imem_rvalid) begin
                    req      = 1'b1;
                    req_addr = PCSrcE ? PCTargetE : pcf_q;
                    state_d  = WAIT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pcf_q       <= RESET_PC;
            instr_buf_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            instr_buf_q <= instr_buf_d;
        end
    end

    // IDLE requests unconditionally, so gate the strobe while reset is held
    assign imem.imem_req  = req && rst_n;
    assign imem.imem_addr = req_addr;

    assign RD          = (state_q == WAIT) ? imem.imem_rdata : instr_buf_q;
    assign PC          = pcf_q;
    assign PCPlus4     = pc_plus4;
    assign InstrValidF = instr_vld;

endmodule
